// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern generator (BINARY / SCAN / FILL / BLINK) stepped by a prescaler tick.
// Optional feature macro: LED_PWM_EN adds a brightness port and PWM gating of the LED outputs.
module led_pattern_gen #(
    parameter int N_LEDS     = 8,
    parameter int PRESCALE_W = 18,
    parameter int PWM_W      = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              mode_load,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0]  brightness,
`endif
    output logic              tick,
    output logic              mode_ack,
    output logic [1:0]        cur_mode,
    output logic [N_LEDS-1:0] leds
);

    localparam int POS_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int FILL_W = $clog2(N_LEDS + 1);

    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(N_LEDS - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N_LEDS);

    typedef enum logic [1:0] {
        MODE_BINARY = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    logic [PRESCALE_W-1:0] prescaler;
    mode_e                 cur_mode_q;
    mode_e                 pend_mode;
    logic                  pend_valid;

    logic [N_LEDS-1:0]     step;
    logic [POS_W-1:0]      pos;
    logic                  dir_up;
    logic [FILL_W-1:0]     fill;
    logic                  phase;

    logic [N_LEDS-1:0]     pattern;

    // NOTE: all state below is sequential, so it uses non-blocking assignments only;
    // blocking here would let later statements see updated values within the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prescaler  <= '0;
            tick       <= 1'b0;
            mode_ack   <= 1'b0;
            cur_mode_q <= MODE_BINARY;
            pend_mode  <= MODE_BINARY;
            pend_valid <= 1'b0;
            step       <= '0;
            pos        <= '0;
            dir_up     <= 1'b1;
            fill       <= '0;
            phase      <= 1'b0;
        end else begin
            tick     <= 1'b0;
            mode_ack <= 1'b0;
            if (en) begin
                prescaler <= prescaler + 1'b1;
                tick      <= (prescaler == '1);

                if (tick) begin
                    if (pend_valid) begin
                        // Apply restarts the pattern instead of advancing it.
                        cur_mode_q <= pend_mode;
                        mode_ack   <= 1'b1;
                        pend_valid <= 1'b0;
                        step       <= '0;
                        pos        <= '0;
                        dir_up     <= 1'b1;
                        fill       <= '0;
                        phase      <= 1'b0;
                    end else begin
                        unique case (cur_mode_q)
                            MODE_BINARY: step <= step + 1'b1;
                            MODE_SCAN: begin
                                if (N_LEDS > 1) begin
                                    if (dir_up) begin
                                        if (pos == POS_LAST) begin
                                            dir_up <= 1'b0;
                                            pos    <= pos - 1'b1;
                                        end else begin
                                            pos <= pos + 1'b1;
                                        end
                                    end else begin
                                        if (pos == '0) begin
                                            dir_up <= 1'b1;
                                            pos    <= pos + 1'b1;
                                        end else begin
                                            pos <= pos - 1'b1;
                                        end
                                    end
                                end
                            end
                            MODE_FILL: fill <= (fill == FILL_MAX) ? '0 : fill + 1'b1;
                            MODE_BLINK: phase <= ~phase;
                            default: ;
                        endcase
                    end
                end

                // Placed after the apply so a load on a tick edge stays pending for the next tick.
                if (mode_load) begin
                    pend_mode  <= mode_e'(mode);
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    // NOTE: pattern gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        pattern = '0;
        unique case (cur_mode_q)
            MODE_BINARY: pattern = step;
            MODE_SCAN: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    pattern[i] = (pos == POS_W'(i));
                end
            end
            MODE_FILL: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    pattern[i] = (FILL_W'(i) < fill);
                end
            end
            MODE_BLINK: pattern = {N_LEDS{phase}};
            default: pattern = '0;
        endcase
    end

    assign cur_mode = cur_mode_q;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_ctr;
    logic             pwm_on;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pwm_ctr <= '0;
        end else if (en) begin
            pwm_ctr <= pwm_ctr + 1'b1;
        end
    end

    // Full-scale brightness is forced on; otherwise the counter would leave one dark slot.
    assign pwm_on = (brightness == '1) || (pwm_ctr < brightness);
    assign leds   = pattern & {N_LEDS{pwm_on}};
`else
    assign leds = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (N_LEDS=4, PRESCALE_W=2, PWM_W=4).
// The brightness section is compiled only when LED_PWM_EN is defined, matching the DUT build.
module tb_led_pattern_gen;

    logic       clk;
    logic       resetn;
    logic       en;
    logic [1:0] mode;
    logic       mode_load;
    logic       tick;
    logic       mode_ack;
    logic [1:0] cur_mode;
    logic [3:0] leds;
`ifdef LED_PWM_EN
    logic [3:0] brightness;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    led_pattern_gen #(
        .N_LEDS    (4),
        .PRESCALE_W(2),
        .PWM_W     (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .mode      (mode),
        .mode_load (mode_load),
`ifdef LED_PWM_EN
        .brightness(brightness),
`endif
        .tick      (tick),
        .mode_ack  (mode_ack),
        .cur_mode  (cur_mode),
        .leds      (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check("tick_seen", tick, 1);
    endtask

    // Wait for the tick, then one more edge so the pattern update is visible.
    task automatic next_tick();
        wait_tick();
        step();
    endtask

    task automatic load(input logic [1:0] m);
        mode      = m;
        mode_load = 1'b1;
        step();
        mode_load = 1'b0;
    endtask

    logic [3:0] scan_exp [7];
    logic [3:0] fill_exp [5];
    logic [3:0] exp_leds;
    logic       exp_phase;

    initial begin
        scan_exp = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        fill_exp = '{4'h1, 4'h3, 4'h7, 4'hf, 4'h0};

        resetn    = 1'b0;
        en        = 1'b1;
        mode      = 2'd0;
        mode_load = 1'b0;
`ifdef LED_PWM_EN
        brightness = 4'hf;
`endif

        // Reset state
        repeat (3) step();
        check("rst_leds", leds, 0);
        check("rst_tick", tick, 0);
        check("rst_mode", cur_mode, 0);
        check("rst_ack", mode_ack, 0);

        // First tick lands in cycle 4 after release
        resetn = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            check("tick_early", tick, 0);
        end
        step();
        check("tick_cycle4", tick, 1);
        step();
        check("tick_width", tick, 0);
        check("bin_1", leds, 4'h1);

        // BINARY counting and enable freeze
        repeat (4) next_tick();
        check("bin_5", leds, 4'h5);
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("en0_tick", tick, 0);
        end
        check("en0_hold", leds, 4'h5);
        en = 1'b1;
        repeat (11) next_tick();
        check("bin_wrap", leds, 4'h0);

        // SCAN
        load(2'd1);
        next_tick();
        check("scan_ack", mode_ack, 1);
        check("scan_mode", cur_mode, 1);
        check("scan_init", leds, 4'h1);
        step();
        check("scan_ack_width", mode_ack, 0);
        for (int i = 0; i < 7; i++) begin
            next_tick();
            check("scan_seq", leds, scan_exp[i]);
        end

        // FILL
        load(2'd2);
        next_tick();
        check("fill_ack", mode_ack, 1);
        check("fill_init", leds, 4'h0);
        for (int i = 0; i < 5; i++) begin
            next_tick();
            check("fill_seq", leds, fill_exp[i]);
        end

        // BLINK
        load(2'd3);
        next_tick();
        check("blink_ack", mode_ack, 1);
        check("blink_init", leds, 4'h0);
        next_tick();
        check("blink_on", leds, 4'hf);
        next_tick();
        check("blink_off", leds, 4'h0);

        // Load on a tick edge waits; a later load overwrites it
        wait_tick();
        mode      = 2'd2;
        mode_load = 1'b1;
        step();
        mode_load = 1'b0;
        check("coinc_no_ack", mode_ack, 0);
        check("coinc_mode", cur_mode, 3);
        check("coinc_adv", leds, 4'hf);
        load(2'd3);
        next_tick();
        check("last_ack", mode_ack, 1);
        check("last_mode", cur_mode, 3);
        check("last_restart", leds, 4'h0);
        next_tick();
        check("single_ack", mode_ack, 0);
        check("single_adv", leds, 4'hf);

        // Load with en low is ignored
        en        = 1'b0;
        mode      = 2'd0;
        mode_load = 1'b1;
        step();
        mode_load = 1'b0;
        en        = 1'b1;
        next_tick();
        check("en0_load_ack", mode_ack, 0);
        check("en0_load_mode", cur_mode, 3);
        check("en0_load_adv", leds, 4'h0);

        // Reset discards a pending mode
        load(2'd1);
        resetn = 1'b0;
        step();
        check("mid_rst_mode", cur_mode, 0);
        check("mid_rst_leds", leds, 0);
        resetn = 1'b1;
        next_tick();
        check("mid_rst_ack", mode_ack, 0);
        check("mid_rst_mode2", cur_mode, 0);
        check("mid_rst_bin", leds, 4'h1);

`ifdef LED_PWM_EN
        // BLINK under PWM: phase high for k%8 in 1..4 (k>=9), gate open for k%16 < brightness
        for (int b = 0; b < 3; b++) begin
            brightness = (b == 0) ? 4'd4 : ((b == 1) ? 4'd0 : 4'd15);
            resetn = 1'b0;
            step();
            resetn    = 1'b1;
            mode      = 2'd3;
            mode_load = 1'b1;
            step();
            mode_load = 1'b0;
            for (int k = 2; k <= 40; k++) begin
                step();
                if (k >= 9) begin
                    exp_phase = (((k - 9) % 8) < 4);
                    exp_leds  = (exp_phase && (brightness == 4'd15 || (k % 16) < int'(brightness)))
                                ? 4'hf : 4'h0;
                    check($sformatf("pwm_b%0d_k%0d", brightness, k), leds, exp_leds);
                end
            end
            check("pwm_mode", cur_mode, 3);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
